// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, single-port data-memory handshake with a
// bounded wait, and the MEM/WB register that feeds writeback and the m2x taps.
//
// state | meaning
// IDLE  | no access in flight; a new request may complete with zero wait
// WAIT  | request outstanding, counting cycles until mem_done or TIMEOUT
module mem_stage #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [15:0] ex_aluFinal,
  input  logic [15:0] ex_wrtData,
  input  logic [15:0] ex_addPC,
  input  logic [15:0] ex_imm8,
  input  logic        ex_memRead,
  input  logic        ex_memWrite,
  input  logic [1:0]  ex_wbDataSel,
  input  logic        ex_regWrite,
  input  logic [2:0]  ex_writeReg,
  input  logic        ex_halt,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        stall,
  output logic        wb_valid,
  output logic [15:0] wb_aluData,
  output logic [15:0] wb_memData,
  output logic [15:0] wb_addPC,
  output logic [15:0] wb_imm8,
  output logic [1:0]  wb_wbDataSel,
  output logic        wb_regWrite,
  output logic [2:0]  wb_writeReg,
  output logic        wb_halt,
  output logic        wb_err
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  logic        m_valid;
  logic [15:0] m_aluFinal;
  logic [15:0] m_wrtData;
  logic [15:0] m_addPC;
  logic [15:0] m_imm8;
  logic        m_memRead;
  logic        m_memWrite;
  logic [1:0]  m_wbDataSel;
  logic        m_regWrite;
  logic [2:0]  m_writeReg;
  logic        m_halt;

  logic memop, mis, at_limit, timeout, rd_done, err_now;

  // A misaligned access never reaches memory; the fields are held by the
  // EX/MEM register, so the drive stays stable for the whole access.
  assign memop     = m_valid & (m_memRead | m_memWrite);
  assign mis       = memop & m_aluFinal[0];
  assign mem_req   = memop & ~mis;
  assign mem_wr    = m_memWrite;
  assign mem_addr  = m_aluFinal;
  assign mem_wdata = m_wrtData;

  // The timeout cycle releases the stall so the aborted op retires as an error.
  assign at_limit = (state == WAIT) && (cnt == CNT_W'(TIMEOUT));
  assign stall    = mem_req & ~mem_done & ~at_limit;
  assign timeout  = mem_req & ~mem_done & at_limit;
  assign rd_done  = mem_req & mem_done & ~m_memWrite;
  assign err_now  = mis | timeout;

  // EX/MEM register: frozen while an access is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid     <= 1'b0;
      m_aluFinal  <= '0;
      m_wrtData   <= '0;
      m_addPC     <= '0;
      m_imm8      <= '0;
      m_memRead   <= 1'b0;
      m_memWrite  <= 1'b0;
      m_wbDataSel <= '0;
      m_regWrite  <= 1'b0;
      m_writeReg  <= '0;
      m_halt      <= 1'b0;
    end else if (!stall) begin
      m_valid     <= ex_valid;
      m_aluFinal  <= ex_aluFinal;
      m_wrtData   <= ex_wrtData;
      m_addPC     <= ex_addPC;
      m_imm8      <= ex_imm8;
      m_memRead   <= ex_memRead;
      m_memWrite  <= ex_memWrite;
      m_wbDataSel <= ex_wbDataSel;
      m_regWrite  <= ex_regWrite;
      m_writeReg  <= ex_writeReg;
      m_halt      <= ex_halt;
    end
  end

  // Handshake FSM state and wait counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: count wait cycles until completion or timeout.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (mem_req && !mem_done) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (!mem_req || mem_done || at_limit) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // MEM/WB register: bubble while stalled, otherwise retire the EX/MEM op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_aluData   <= '0;
      wb_memData   <= '0;
      wb_addPC     <= '0;
      wb_imm8      <= '0;
      wb_wbDataSel <= '0;
      wb_regWrite  <= 1'b0;
      wb_writeReg  <= '0;
      wb_halt      <= 1'b0;
      wb_err       <= 1'b0;
    end else if (stall) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid     <= m_valid;
      wb_aluData   <= m_aluFinal;
      wb_memData   <= rd_done ? mem_rdata : 16'h0000;
      wb_addPC     <= m_addPC;
      wb_imm8      <= m_imm8;
      wb_wbDataSel <= m_wbDataSel;
      wb_regWrite  <= m_regWrite & ~err_now;
      wb_writeReg  <= m_writeReg;
      wb_halt      <= m_halt;
      wb_err       <= err_now;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected MEM/WB records are queued when an
// instruction is driven and matched against records captured when wb_valid=1.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [15:0] ex_aluFinal, ex_wrtData, ex_addPC, ex_imm8;
  logic        ex_memRead, ex_memWrite;
  logic [1:0]  ex_wbDataSel;
  logic        ex_regWrite;
  logic [2:0]  ex_writeReg;
  logic        ex_halt;
  logic        mem_req, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_done;
  logic        stall;
  logic        wb_valid;
  logic [15:0] wb_aluData, wb_memData, wb_addPC, wb_imm8;
  logic [1:0]  wb_wbDataSel;
  logic        wb_regWrite;
  logic [2:0]  wb_writeReg;
  logic        wb_halt, wb_err;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_aluFinal(ex_aluFinal), .ex_wrtData(ex_wrtData),
    .ex_addPC(ex_addPC), .ex_imm8(ex_imm8), .ex_memRead(ex_memRead),
    .ex_memWrite(ex_memWrite), .ex_wbDataSel(ex_wbDataSel),
    .ex_regWrite(ex_regWrite), .ex_writeReg(ex_writeReg), .ex_halt(ex_halt),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall(stall), .wb_valid(wb_valid), .wb_aluData(wb_aluData),
    .wb_memData(wb_memData), .wb_addPC(wb_addPC), .wb_imm8(wb_imm8),
    .wb_wbDataSel(wb_wbDataSel), .wb_regWrite(wb_regWrite),
    .wb_writeReg(wb_writeReg), .wb_halt(wb_halt), .wb_err(wb_err)
  );

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] mem;
    logic [15:0] pc;
    logic [15:0] imm;
    logic [1:0]  sel;
    logic        rw;
    logic [2:0]  wreg;
    logic        halt;
    logic        err;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];
  int   obs_cyc[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc, req_seen, stall_seen;

  function automatic rec_t mk(input logic [15:0] alu, input logic [15:0] mem,
                              input logic [15:0] pc, input logic rw,
                              input logic [2:0] wreg, input logic halt,
                              input logic err);
    rec_t r;
    r.alu = alu; r.mem = mem; r.pc = pc; r.imm = 16'h00A0; r.sel = 2'b01;
    r.rw = rw; r.wreg = wreg; r.halt = halt; r.err = err;
    return r;
  endfunction

  task automatic set_ex(input logic rd, input logic wr, input logic [15:0] alu,
                        input logic [15:0] wd, input logic [15:0] pc,
                        input logic rw, input logic [2:0] wreg, input logic halt);
    ex_valid = 1'b1; ex_memRead = rd; ex_memWrite = wr; ex_aluFinal = alu;
    ex_wrtData = wd; ex_addPC = pc; ex_imm8 = 16'h00A0; ex_wbDataSel = 2'b01;
    ex_regWrite = rw; ex_writeReg = wreg; ex_halt = halt;
  endtask

  task automatic idle_ex();
    ex_valid = 1'b0;
  endtask

  // Advance to the next falling edge and record what the DUT shows there.
  task automatic tick();
    rec_t r;
    @(negedge clk);
    cyc++;
    if (mem_req) req_seen++;
    if (stall) stall_seen++;
    if (wb_valid) begin
      r.alu = wb_aluData; r.mem = wb_memData; r.pc = wb_addPC; r.imm = wb_imm8;
      r.sel = wb_wbDataSel; r.rw = wb_regWrite; r.wreg = wb_writeReg;
      r.halt = wb_halt; r.err = wb_err;
      obs_q.push_back(r);
      obs_cyc.push_back(cyc);
    end
  endtask

  task automatic begin_test();
    cyc = 0; req_seen = 0; stall_seen = 0;
    exp_q.delete(); obs_q.delete(); obs_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_done = 1'b0; mem_rdata = 16'h0000;
    ex_valid = 1'b0; ex_aluFinal = '0; ex_wrtData = '0; ex_addPC = '0;
    ex_imm8 = '0; ex_memRead = 1'b0; ex_memWrite = 1'b0; ex_wbDataSel = '0;
    ex_regWrite = 1'b0; ex_writeReg = '0; ex_halt = 1'b0;
    #1;
    checks++; if ({mem_req, stall} !== 2'b00) $display("FAIL reset_req_stall: got %b want 00", {mem_req, stall}); else passed++;
    checks++; if ({wb_valid, wb_err, wb_regWrite} !== 3'b000) $display("FAIL reset_wb_flags: got %b want 000", {wb_valid, wb_err, wb_regWrite}); else passed++;
    checks++; if (wb_aluData !== 16'h0000) $display("FAIL reset_wb_alu: got %h want 0000", wb_aluData); else passed++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu();
    rec_t e, o;
    begin_test();
    set_ex(1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0102, 1'b1, 3'd3, 1'b0);
    exp_q.push_back(mk(16'h1234, 16'h0000, 16'h0102, 1'b1, 3'd3, 1'b0, 1'b0));
    tick();
    idle_ex();
    repeat (3) tick();
    checks++; if (req_seen != 0) $display("FAIL alu_no_req: req cycles %0d want 0", req_seen); else passed++;
    checks++; if (obs_cyc.size() == 0 || obs_cyc[0] != 2) $display("FAIL alu_latency: got %0d want 2", obs_cyc.size() == 0 ? -1 : obs_cyc[0]); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL alu_wb: got none want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL alu_wb: got %h want %h", o, e); else passed++;
      end
    end
  endtask

  task automatic test_load_zero_wait();
    rec_t e, o;
    begin_test();
    set_ex(1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0200, 1'b1, 3'd5, 1'b0);
    mem_done = 1'b1; mem_rdata = 16'hBEEF;
    exp_q.push_back(mk(16'h0040, 16'hBEEF, 16'h0200, 1'b1, 3'd5, 1'b0, 1'b0));
    tick();
    idle_ex();
    tick();
    mem_done = 1'b0; mem_rdata = 16'h0000;
    repeat (2) tick();
    checks++; if (stall_seen != 0) $display("FAIL ld0_stall: stall cycles %0d want 0", stall_seen); else passed++;
    checks++; if (req_seen != 1) $display("FAIL ld0_req: req cycles %0d want 1", req_seen); else passed++;
    checks++; if (obs_cyc.size() == 0 || obs_cyc[0] != 2) $display("FAIL ld0_latency: got %0d want 2", obs_cyc.size() == 0 ? -1 : obs_cyc[0]); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL ld0_wb: got none want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL ld0_wb: got %h want %h", o, e); else passed++;
      end
    end
  endtask

  task automatic test_store_wait();
    rec_t e, o;
    begin_test();
    set_ex(1'b0, 1'b1, 16'h0010, 16'hA5A5, 16'h0300, 1'b0, 3'd2, 1'b0);
    exp_q.push_back(mk(16'h0010, 16'h0000, 16'h0300, 1'b0, 3'd2, 1'b0, 1'b0));
    tick();
    checks++; if ({mem_req, mem_wr, mem_addr, mem_wdata} !== {2'b11, 16'h0010, 16'hA5A5}) $display("FAIL st_drive_c1: got %b %b %h %h want 1 1 0010 a5a5", mem_req, mem_wr, mem_addr, mem_wdata); else passed++;
    idle_ex();
    tick();
    checks++; if ({mem_req, mem_wr, mem_addr, mem_wdata} !== {2'b11, 16'h0010, 16'hA5A5}) $display("FAIL st_drive_c2: got %b %b %h %h want 1 1 0010 a5a5", mem_req, mem_wr, mem_addr, mem_wdata); else passed++;
    checks++; if (wb_valid !== 1'b0) $display("FAIL st_bubble: wb_valid %b want 0", wb_valid); else passed++;
    mem_done = 1'b1;
    #1;
    checks++; if ({stall, mem_req, mem_wr, mem_addr, mem_wdata} !== {3'b011, 16'h0010, 16'hA5A5}) $display("FAIL st_done_cycle: got %b %b %b %h %h want 0 1 1 0010 a5a5", stall, mem_req, mem_wr, mem_addr, mem_wdata); else passed++;
    tick();
    mem_done = 1'b0;
    repeat (2) tick();
    checks++; if (stall_seen != 2) $display("FAIL st_stall_len: stall cycles %0d want 2", stall_seen); else passed++;
    checks++; if (obs_cyc.size() == 0 || obs_cyc[0] != 3) $display("FAIL st_latency: got %0d want 3", obs_cyc.size() == 0 ? -1 : obs_cyc[0]); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL st_wb: got none want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL st_wb: got %h want %h", o, e); else passed++;
      end
    end
    checks++; if (obs_q.size() != 0) $display("FAIL st_wb_once: extra records %0d want 0", obs_q.size()); else passed++;
  endtask

  task automatic test_misaligned();
    rec_t e, o;
    begin_test();
    set_ex(1'b1, 1'b0, 16'h0011, 16'h0000, 16'h0400, 1'b1, 3'd6, 1'b0);
    mem_done = 1'b0;
    exp_q.push_back(mk(16'h0011, 16'h0000, 16'h0400, 1'b0, 3'd6, 1'b0, 1'b1));
    tick();
    idle_ex();
    repeat (2) tick();
    checks++; if ({req_seen, stall_seen} != {32'd0, 32'd0}) $display("FAIL mis_no_req: req %0d stall %0d want 0 0", req_seen, stall_seen); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL mis_wb: got none want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL mis_wb: got %h want %h", o, e); else passed++;
      end
    end
  endtask

  task automatic test_timeout();
    rec_t e, o;
    int n;
    begin_test();
    set_ex(1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0500, 1'b1, 3'd7, 1'b0);
    mem_done = 1'b0;
    exp_q.push_back(mk(16'h0020, 16'h0000, 16'h0500, 1'b0, 3'd7, 1'b0, 1'b1));
    tick();
    idle_ex();
    n = 0;
    while (obs_q.size() == 0 && n < 30) begin
      tick();
      n++;
    end
    checks++; if ({mem_req, stall} !== 2'b00) $display("FAIL to_release: req/stall %b want 00", {mem_req, stall}); else passed++;
    checks++; if (stall_seen != 15) $display("FAIL to_stall_len: stall cycles %0d want 15", stall_seen); else passed++;
    checks++; if (obs_cyc.size() == 0 || obs_cyc[0] != 17) $display("FAIL to_latency: got %0d want 17", obs_cyc.size() == 0 ? -1 : obs_cyc[0]); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL to_wb: got none want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL to_wb: got %h want %h", o, e); else passed++;
      end
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_in_wait();
    begin_test();
    set_ex(1'b1, 1'b0, 16'h0030, 16'h0000, 16'h0600, 1'b1, 3'd4, 1'b0);
    mem_done = 1'b0;
    tick();
    idle_ex();
    repeat (2) tick();
    checks++; if ({mem_req, stall} !== 2'b11) $display("FAIL rw_pre: req/stall %b want 11", {mem_req, stall}); else passed++;
    rst = 1'b1;
    #1;
    checks++; if ({mem_req, stall, wb_valid, wb_err, wb_regWrite, wb_halt} !== 6'b0) $display("FAIL rw_flags: got %b want 000000", {mem_req, stall, wb_valid, wb_err, wb_regWrite, wb_halt}); else passed++;
    checks++; if ({wb_aluData, wb_memData, wb_addPC, wb_imm8} !== 64'h0) $display("FAIL rw_data: got %h want 0", {wb_aluData, wb_memData, wb_addPC, wb_imm8}); else passed++;
    #2;
    rst = 1'b0;
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    mem_done = 1'b0; mem_rdata = 16'h0000;
    repeat (2) tick();
    checks++; if (obs_q.size() != 0 || wb_memData !== 16'h0000) $display("FAIL rw_late_done: records %0d memData %h want 0 0000", obs_q.size(), wb_memData); else passed++;
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    begin_test();
    set_ex(1'b0, 1'b0, 16'h1111, 16'h0000, 16'h0700, 1'b1, 3'd1, 1'b0);
    exp_q.push_back(mk(16'h1111, 16'h0000, 16'h0700, 1'b1, 3'd1, 1'b0, 1'b0));
    tick();
    set_ex(1'b0, 1'b0, 16'h2222, 16'h0000, 16'h0702, 1'b1, 3'd2, 1'b1);
    exp_q.push_back(mk(16'h2222, 16'h0000, 16'h0702, 1'b1, 3'd2, 1'b1, 1'b0));
    tick();
    set_ex(1'b1, 1'b0, 16'h0050, 16'h0000, 16'h0704, 1'b1, 3'd6, 1'b0);
    mem_done = 1'b1; mem_rdata = 16'h7777;
    exp_q.push_back(mk(16'h0050, 16'h7777, 16'h0704, 1'b1, 3'd6, 1'b0, 1'b0));
    tick();
    idle_ex();
    tick();
    mem_done = 1'b0; mem_rdata = 16'h0000;
    repeat (2) tick();
    checks++; if (stall_seen != 0) $display("FAIL b2b_stall: stall cycles %0d want 0", stall_seen); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL b2b_wb: got none want %h", e);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL b2b_wb: got %h want %h", o, e); else passed++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d so far", passed, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu();
    test_load_zero_wait();
    test_store_wait();
    test_misaligned();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline, directly downstream of execute.
- Captures execute results into the EX/MEM register and runs the single-port data-memory handshake for LD/ST/STU.
- Stalls upstream stages while an access is outstanding, then registers results into the MEM/WB register.
- The MEM/WB register feeds writeback and the m2x forwarding taps back into execute.

Parameters:
TIMEOUT, 15, max cycles an access may wait for mem_done before it is aborted with an error
CNT_W, 4, width of the wait counter; must hold TIMEOUT

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
ex_valid  in  1  execute holds a real instruction this cycle
ex_aluFinal  in  16  ALU/set-op result; also the memory address
ex_wrtData  in  16  store data, already forwarded
ex_addPC  in  16  link/next-PC value
ex_imm8  in  16  extended imm8 (LBI/SLBI writeback)
ex_memRead  in  1  load
ex_memWrite  in  1  store
ex_wbDataSel  in  2  writeback source select, passed through
ex_regWrite  in  1  register write enable
ex_writeReg  in  3  destination register
ex_halt  in  1  HALT instruction
mem_req  out  1  data memory request
mem_wr  out  1  1=write, 0=read; valid while mem_req
mem_addr  out  16  access address
mem_wdata  out  16  store data
mem_rdata  in  16  read data; valid in the mem_done cycle
mem_done  in  1  one-cycle completion pulse
stall  out  1  freeze PC/IF/ID/EX and the EX/MEM register
wb_valid  out  1  MEM/WB register holds an instruction
wb_aluData  out  16  m2xALUData tap
wb_memData  out  16  m2xMemData tap
wb_addPC  out  16  m2xAddPCData tap
wb_imm8  out  16  m2xImm8Data tap
wb_wbDataSel  out  2  passed through
wb_regWrite  out  1  gated write enable
wb_writeReg  out  3  passed through
wb_halt  out  1  passed through
wb_err  out  1  misaligned access or timeout

Behaviour:
- Reset:
  - Every output and register returns to 0 asynchronously, including mem_req and stall.
  - FSM returns to IDLE and the counter to 0.
  - A reset during WAIT aborts the access; a late mem_done afterwards is ignored.
- EX/MEM register (m_*):
  - Loads all ex_* fields on an edge where stall=0.
  - Holds its contents when stall=1.
  - m_valid = ex_valid at load time.
- Memory op: memop = m_valid & (m_memRead | m_memWrite).
- Misalignment: mis = memop & m_aluFinal[0].
- Memory drive outputs:
  - mem_req = memop & ~mis & (state==IDLE | state==WAIT).
  - mem_wr = m_memWrite.
  - mem_addr = m_aluFinal.
  - mem_wdata = m_wrtData.
  - All four are stable for the whole access.
- FSM, 2 states:
  - IDLE:
    - If mem_req & mem_done: zero-wait completion, no stall, stay IDLE.
    - If mem_req & ~mem_done: go to WAIT, counter <= 1.
  - WAIT:
    - If mem_done: complete, go to IDLE.
    - Else if counter == TIMEOUT: abort, err, go to IDLE.
    - Else counter <= counter + 1.
- Stall rule: stall = mem_req & ~mem_done & ~(state==WAIT & counter==TIMEOUT). Combinational from mem_done, so there is no extra bubble on completion.
- mem_done with mem_req=0 is ignored.
- MEM/WB register, loaded every edge:
  - When stall=1: wb_valid <= 0 (bubble) and the other wb_* fields hold.
  - Otherwise: wb_* <= m_*, and wb_valid <= m_valid.
  - wb_memData <= mem_rdata on read completion, 0 otherwise.
- Errors:
  - wb_err <= mis or timeout.
  - An erroring instruction gets wb_regWrite <= 0.
  - A misaligned access issues no request.
- Stores: wb_regWrite passes through unchanged. STU writes its base register from m_aluFinal.
- Non-memory instructions take 1 cycle through the stage, with no stall and no request.

Test Plan:
- ALU op, ex_aluFinal=0x1234, regWrite=1, writeReg=3 -> 2 edges later wb_aluData=0x1234, wb_regWrite=1, wb_writeReg=3; mem_req never asserted.
- LD addr 0x0040, mem_done tied high with rdata=0xBEEF -> stall never asserted; next edge wb_memData=0xBEEF, wb_valid=1.
- ST addr 0x0010, data 0xA5A5, mem_done after 3 cycles -> mem_req/mem_wr/addr/wdata stable for 3 cycles; stall=1 for exactly 2 cycles; wb_valid=0 during the stall, then 1 for one cycle.
- LD addr 0x0011 -> no mem_req, no stall; wb_err=1, wb_regWrite=0.
- LD, mem_done never arrives, TIMEOUT=15 -> stall for 15 cycles, then released; wb_err=1, FSM back to IDLE.
- rst pulsed in 2nd WAIT cycle -> mem_req, stall and all wb_* go to 0 immediately; mem_done next cycle causes no writeback.
